mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Multi-cycle load/store unit for the MEM stage. Aligns store data, generates byte enables and
//  issues one request to data memory over a valid/ready handshake. Waits for a variable-latency
//  read response, then returns the sign- or zero-extended load result.
//  Misaligned accesses raise AdEL/AdES without touching memory; busy stalls the pipeline.
// PARAMETERS
//  DATA_W  32  memory word width; 32 or 64 only (other values fatal at elaboration)
//  ADDR_W  32  byte address width
// PORTS
//  clk            in   1          clock, all state on rising edge
//  reset          in   1          synchronous, active-high
//  req_valid      in   1          MEM stage presents an access
//  req_ready      out  1          unit idle, request accepted when req_valid&req_ready
//  req_we         in   1          1 store, 0 load
//  req_op         in   3          size/extension code (see BEHAVIOUR)
//  req_addr       in   ADDR_W     byte address
//  req_wdata      in   DATA_W     store data, right-justified
//  mem_req_valid  out  1          request to memory
//  mem_req_ready  in   1          memory accepts request
//  mem_we         out  1          write strobe
//  mem_addr       out  ADDR_W     word-aligned address (low log2(DATA_W/8) bits zero)
//  mem_be         out  DATA_W/8   byte enables
//  mem_wdata      out  DATA_W     store data shifted to byte lane
//  mem_rsp_valid  in   1          read data valid (loads only)
//  mem_rsp_data   in   DATA_W     raw read word
//  busy           out  1          access in flight (state != IDLE)
//  done           out  1          one-cycle completion pulse
//  rdata          out  DATA_W     extended load result, valid with done&~exc
//  exc            out  1          address exception, valid with done
//  exc_code       out  5          4 = AdEL, 5 = AdES, else 0
// BEHAVIOUR
//  req_op: 000 full word(DATA_W), 001 bu, 010 b, 011 hu, 100 h, 101 wu, 110 w(sext), 111 reserved.
//   101/110 legal only when DATA_W=64; for DATA_W=32 they and 111 act as 000.
//  Alignment: h/hu need addr[0]=0; w/wu need addr[1:0]=0; full word needs all lane bits 0.
//  FSM IDLE->REQ->WAIT->RESP->IDLE; state registered, request fields latched on accept.
//   IDLE: req_ready=1. Accept -> REQ, or -> RESP with exc=1 if misaligned (no memory access).
//   REQ: mem_req_valid=1, outputs held stable until mem_req_ready.
//    store & ready -> RESP. load & ready -> WAIT.
//    load & ready & mem_rsp_valid in the same cycle -> capture data, go to RESP.
//   WAIT: capture mem_rsp_data on mem_rsp_valid -> RESP.
//   RESP: done=1 for exactly one cycle, rdata/exc/exc_code driven, then -> IDLE.
//  Latency: accept at cycle t; mem_req_valid from t+1; done no earlier than t+2;
//   misaligned -> done at t+1.
//  Load extension: lane = addr low bits; sub-word fields sign- or zero-extended to DATA_W.
//  Store: mem_wdata = req_wdata replicated/shifted to lane; mem_be set only for written bytes.
//  mem_rsp_valid outside WAIT/REQ-load is ignored.
//  Registered outputs (rdata, mem_*) hold their last value when not qualified.
//  Reset (any state, mid-access included): state=IDLE.
//   mem_req_valid, done, exc, busy = 0; exc_code = 0; rdata, mem_addr, mem_be, mem_wdata = 0.
//   The in-flight access is dropped; a late response is ignored.
// STRUCTURE
//  Shared package mau_pkg: op codes, EXC_ADEL=5'd4 / EXC_ADES=5'd5, FSM state enum, lane-width
//   function.
//  Sub-module load_ext (combinational, parameter DATA_W): raw word + op + lane -> extended data.
//  Top: FSM, request latch, store aligner / byte-enable generator.
// TESTING (DATA_W=32 unless noted)
//  lb addr 0x..03, rsp 0x80FF_1234 after 3 cycles -> done once, rdata=0xFFFF_FF80, busy high
//   throughout.
//  sh addr 0x..02, wdata 0x0000_BEEF -> mem_be=4'b1100, mem_wdata=0xBEEF_xxxx in upper half,
//   done 1 cycle after ready.
//  lh addr 0x..01 -> no mem_req_valid; done at t+1, exc=1, exc_code=4; sw 0x..02 -> exc_code=5.
//  mem_req_ready low 4 cycles -> mem_addr/mem_be/mem_wdata stable; ready+rsp same cycle
//   -> done next cycle.
//  reset in WAIT, then rsp arrives -> no done, req_ready=1 next cycle.
//  DATA_W=64: lw addr 0x..04, rsp 0x8000_0001_xxxx_xxxx -> rdata=0xFFFF_FFFF_8000_0001;
//   sd mem_be=8'hFF.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, exception codes,
// FSM states and lane helpers.
package mau_pkg;

    localparam logic [2:0] OP_FULL = 3'b000;
    localparam logic [2:0] OP_BU   = 3'b001;
    localparam logic [2:0] OP_B    = 3'b010;
    localparam logic [2:0] OP_HU   = 3'b011;
    localparam logic [2:0] OP_H    = 3'b100;
    localparam logic [2:0] OP_WU   = 3'b101;
    localparam logic [2:0] OP_W    = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Number of address bits selecting a byte lane within one memory word.
    function automatic int unsigned lane_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Word ops only exist on a 64-bit bus; anything unsupported becomes a full-word access.
    function automatic logic [2:0] norm_op(input logic [2:0] op, input logic wide);
        logic [2:0] res;
        res = op;
        if (op == OP_RSV || (!wide && (op == OP_WU || op == OP_W)))
            res = OP_FULL;
        return res;
    endfunction

    function automatic logic [3:0] op_bytes(input logic [2:0] op, input logic wide);
        logic [3:0] res;
        case (op)
            OP_BU, OP_B: res = 4'd1;
            OP_HU, OP_H: res = 4'd2;
            OP_WU, OP_W: res = 4'd4;
            default:     res = wide ? 4'd8 : 4'd4;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load result formatter: picks the addressed field out of a raw memory word and
// sign- or zero-extends it to the full data width.
module load_ext
    import mau_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]                raw,
    input  logic [2:0]                       op,
    input  logic [lane_bits(DATA_W)-1:0]     lane,
    output logic [DATA_W-1:0]                ext_c
);

    logic [DATA_W-1:0] shifted;

    assign shifted = raw >> {lane, 3'b000};

    always_comb begin
        ext_c = shifted;
        case (op)
            OP_BU:   ext_c = DATA_W'(shifted[7:0]);
            OP_B:    ext_c = DATA_W'($signed(shifted[7:0]));
            OP_HU:   ext_c = DATA_W'(shifted[15:0]);
            OP_H:    ext_c = DATA_W'($signed(shifted[15:0]));
            OP_WU:   ext_c = DATA_W'(shifted[31:0]);
            OP_W:    ext_c = DATA_W'($signed(shifted[31:0]));
            default: ext_c = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: latches one access, checks alignment, aligns store data,
// runs the memory handshake and returns the extended load result with a done pulse.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  exc,
    output logic [4:0]            exc_code
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned LB   = lane_bits(DATA_W);
    localparam logic        WIDE = (DATA_W == 64);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $fatal(1, "mem_access_unit: DATA_W must be 32 or 64");
    end

    state_t            state_q, state_n;
    logic              we_q, we_n;
    logic [2:0]        op_q, op_n;
    logic [LB-1:0]     lane_q, lane_n;

    logic              req_ready_n, mem_req_valid_n, mem_we_n, busy_n, done_n, exc_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [BE_W-1:0]   mem_be_n;
    logic [DATA_W-1:0] mem_wdata_n, rdata_n;
    logic [4:0]        exc_code_n;

    logic [2:0]        op_eff_c;
    logic [3:0]        size_c;
    logic [LB-1:0]     lane_c;
    logic              misaligned_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c, ext_c;
    logic [ADDR_W-1:0] addr_c;

    // Decode of the incoming request; only consumed on the accept cycle.
    assign op_eff_c     = norm_op(req_op, WIDE);
    assign size_c       = op_bytes(op_eff_c, WIDE);
    assign lane_c       = req_addr[LB-1:0];
    assign misaligned_c = (lane_c & LB'(size_c - 4'd1)) != '0;
    assign wdata_c      = req_wdata << {lane_c, 3'b000};
    assign addr_c       = {req_addr[ADDR_W-1:LB], {LB{1'b0}}};

    always_comb begin
        be_c = '0;
        for (int unsigned i = 0; i < BE_W; i++)
            be_c[i] = (i >= 32'(lane_c)) && (i < 32'(lane_c) + 32'(size_c));
    end

    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .raw   (mem_rsp_data),
        .op    (op_q),
        .lane  (lane_q),
        .ext_c (ext_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            op_q          <= OP_FULL;
            lane_q        <= '0;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rdata         <= '0;
            exc           <= 1'b0;
            exc_code      <= '0;
        end else begin
            state_q       <= state_n;
            we_q          <= we_n;
            op_q          <= op_n;
            lane_q        <= lane_n;
            req_ready     <= req_ready_n;
            mem_req_valid <= mem_req_valid_n;
            mem_we        <= mem_we_n;
            mem_addr      <= mem_addr_n;
            mem_be        <= mem_be_n;
            mem_wdata     <= mem_wdata_n;
            busy          <= busy_n;
            done          <= done_n;
            rdata         <= rdata_n;
            exc           <= exc_n;
            exc_code      <= exc_code_n;
        end
    end

    // Next state plus next value of every registered output; unqualified outputs hold.
    always_comb begin
        state_n         = state_q;
        we_n            = we_q;
        op_n            = op_q;
        lane_n          = lane_q;
        mem_req_valid_n = mem_req_valid;
        mem_we_n        = mem_we;
        mem_addr_n      = mem_addr;
        mem_be_n        = mem_be;
        mem_wdata_n     = mem_wdata;
        rdata_n         = rdata;
        exc_n           = exc;
        exc_code_n      = exc_code;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_n       = req_we;
                    op_n       = op_eff_c;
                    lane_n     = lane_c;
                    exc_n      = misaligned_c;
                    exc_code_n = misaligned_c ? (req_we ? EXC_ADES : EXC_ADEL) : 5'd0;
                    if (misaligned_c) begin
                        state_n = ST_RESP;
                    end else begin
                        state_n         = ST_REQ;
                        mem_req_valid_n = 1'b1;
                        mem_we_n        = req_we;
                        mem_addr_n      = addr_c;
                        mem_be_n        = be_c;
                        if (req_we)
                            mem_wdata_n = wdata_c;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_n = 1'b0;
                    if (we_q) begin
                        state_n = ST_RESP;
                    end else if (mem_rsp_valid) begin
                        rdata_n = ext_c;
                        state_n = ST_RESP;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_n = ext_c;
                    state_n = ST_RESP;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        req_ready_n = (state_n == ST_IDLE);
        busy_n      = (state_n != ST_IDLE);
        done_n      = (state_n == ST_RESP);
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 32-bit and a 64-bit instance share stimulus,
// directed vectors plus randomized accesses checked against a byte-level reference model.
module tb_mem_access_unit;

    typedef struct {
        bit        w64;
        bit        we;
        bit [2:0]  op;
        bit [31:0] addr;
        bit [63:0] wdata;
        bit [63:0] rsp;
        int        rdy;
        int        rsp_dly;
        bit        mis;
        bit [4:0]  code;
        bit [31:0] maddr;
        bit [7:0]  be;
        bit [63:0] wd;
        bit [63:0] rd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel64, req_valid, req_we, mem_req_ready, mem_rsp_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rsp_data;

    logic        a_rr, a_mv, a_mwe, a_busy, a_done, a_exc;
    logic [31:0] a_maddr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic [4:0]  a_code;
    logic        b_rr, b_mv, b_mwe, b_busy, b_done, b_exc;
    logic [31:0] b_maddr;
    logic [63:0] b_wdata, b_rdata;
    logic [7:0]  b_be;
    logic [4:0]  b_code;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & ~sel64), .req_ready(a_rr), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .mem_req_valid(a_mv), .mem_req_ready(mem_req_ready & ~sel64), .mem_we(a_mwe),
        .mem_addr(a_maddr), .mem_be(a_be), .mem_wdata(a_wdata),
        .mem_rsp_valid(mem_rsp_valid & ~sel64), .mem_rsp_data(mem_rsp_data[31:0]),
        .busy(a_busy), .done(a_done), .rdata(a_rdata), .exc(a_exc), .exc_code(a_code)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & sel64), .req_ready(b_rr), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(b_mv), .mem_req_ready(mem_req_ready & sel64), .mem_we(b_mwe),
        .mem_addr(b_maddr), .mem_be(b_be), .mem_wdata(b_wdata),
        .mem_rsp_valid(mem_rsp_valid & sel64), .mem_rsp_data(mem_rsp_data),
        .busy(b_busy), .done(b_done), .rdata(b_rdata), .exc(b_exc), .exc_code(b_code)
    );

    // Observed view of whichever instance is selected.
    logic        o_rr, o_mv, o_mwe, o_busy, o_done, o_exc;
    logic [31:0] o_maddr;
    logic [7:0]  o_be;
    logic [63:0] o_wdata, o_rdata;
    logic [4:0]  o_code;
    assign o_rr    = sel64 ? b_rr    : a_rr;
    assign o_mv    = sel64 ? b_mv    : a_mv;
    assign o_mwe   = sel64 ? b_mwe   : a_mwe;
    assign o_busy  = sel64 ? b_busy  : a_busy;
    assign o_done  = sel64 ? b_done  : a_done;
    assign o_exc   = sel64 ? b_exc   : a_exc;
    assign o_maddr = sel64 ? b_maddr : a_maddr;
    assign o_be    = sel64 ? b_be    : {4'b0, a_be};
    assign o_wdata = sel64 ? b_wdata : {32'b0, a_wdata};
    assign o_rdata = sel64 ? b_rdata : {32'b0, a_rdata};
    assign o_code  = sel64 ? b_code  : a_code;

    int    n_chk  = 0;
    int    n_fail = 0;
    string tag    = "init";

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t tv(input bit w64, input bit we, input bit [2:0] op,
                                input bit [31:0] addr, input bit [63:0] wdata, input bit [63:0] rsp,
                                input int rdy, input int rsp_dly, input bit mis, input bit [4:0] code,
                                input bit [31:0] maddr, input bit [7:0] be,
                                input bit [63:0] wd, input bit [63:0] rd);
        vec_t v;
        v.w64 = w64; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.rsp = rsp;
        v.rdy = rdy; v.rsp_dly = rsp_dly; v.mis = mis; v.code = code;
        v.maddr = maddr; v.be = be; v.wd = wd; v.rd = rd;
        return v;
    endfunction

    // Reference model: access size and signedness from the op, lane = addr mod word bytes.
    function automatic vec_t mk(input bit w64, input bit we, input bit [2:0] op,
                                input bit [31:0] addr, input bit [63:0] wdata, input bit [63:0] rsp,
                                input int rdy, input int rsp_dly);
        vec_t v;
        int nb, sz, lane;
        bit sgn;
        bit [63:0] mask, wmask, val;
        nb = w64 ? 8 : 4;
        sz = nb;
        sgn = 1'b0;
        case (op)
            3'd1: sz = 1;
            3'd2: begin sz = 1; sgn = 1'b1; end
            3'd3: sz = 2;
            3'd4: begin sz = 2; sgn = 1'b1; end
            3'd5: if (w64) sz = 4;
            3'd6: if (w64) begin sz = 4; sgn = 1'b1; end
            default: ;
        endcase
        wmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        mask  = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * sz)) - 64'd1;
        lane  = int'(addr % 32'(nb));
        v = tv(w64, we, op, addr, wdata, rsp, rdy, rsp_dly, 1'b0, 5'd0, 32'd0, 8'd0, 64'd0, 64'd0);
        v.mis   = (addr % 32'(sz)) != 32'd0;
        v.code  = v.mis ? (we ? 5'd5 : 5'd4) : 5'd0;
        v.maddr = addr - 32'(lane);
        v.be    = 8'(((1 << sz) - 1) << lane);
        v.wd    = ((wdata & mask) << (8 * lane)) & wmask;
        val     = ((rsp & wmask) >> (8 * lane)) & mask;
        if (sgn && val[8 * sz - 1])
            val = val | ~mask;
        v.rd = val & wmask;
        return v;
    endfunction

    task automatic run(input vec_t v);
        logic [31:0] s_addr;
        logic [7:0]  s_be;
        logic [63:0] s_wd, bem;
        logic        s_we;
        bit          ok;
        sel64 = v.w64;
        #1;
        chk("req_ready", 64'(o_rr), 64'd1);
        req_valid = 1'b1; req_we = v.we; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        req_we = ~v.we; req_op = 3'($urandom); req_addr = $urandom; req_wdata = {$urandom, $urandom};
        if (v.mis) begin
            chk("exc_resp", 64'({o_done, o_exc, o_mv, o_busy}), 64'b1101);
            chk("exc_code", 64'(o_code), 64'(v.code));
        end else begin
            for (int i = 0; i < 8; i++) bem[8*i +: 8] = {8{v.be[i]}};
            chk("issue", 64'({o_mv, o_mwe, o_busy, o_done}), 64'({1'b1, v.we, 1'b1, 1'b0}));
            chk("mem_addr", 64'(o_maddr), 64'(v.maddr));
            chk("mem_be", 64'(o_be), 64'(v.be));
            if (v.we) chk("mem_wdata", o_wdata & bem, v.wd & bem);
            s_addr = o_maddr; s_be = o_be; s_wd = o_wdata; s_we = o_mwe; ok = 1'b1;
            repeat (v.rdy) begin
                tick();
                if (o_maddr !== s_addr || o_be !== s_be || o_wdata !== s_wd || o_mwe !== s_we ||
                    o_mv !== 1'b1 || o_done !== 1'b0) ok = 1'b0;
            end
            if (v.rdy > 0) chk("req_hold", 64'(ok), 64'd1);
            mem_req_ready = 1'b1;
            if (!v.we && v.rsp_dly == 0) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = v.rsp;
            end
            tick();
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = {$urandom, $urandom};
            if (!v.we && v.rsp_dly > 0) begin
                chk("wait", 64'({o_done, o_busy, o_mv}), 64'b010);
                ok = 1'b1;
                repeat (v.rsp_dly - 1) begin
                    tick();
                    if (o_done !== 1'b0 || o_busy !== 1'b1) ok = 1'b0;
                end
                if (v.rsp_dly > 1) chk("wait_hold", 64'(ok), 64'd1);
                mem_rsp_valid = 1'b1; mem_rsp_data = v.rsp;
                tick();
                mem_rsp_valid = 1'b0; mem_rsp_data = {$urandom, $urandom};
            end
            chk("done", 64'({o_done, o_exc, o_busy}), 64'b101);
            if (!v.we) chk("rdata", o_rdata, v.rd);
        end
        tick();
        chk("idle", 64'({o_done, o_busy, o_rr, o_mv}), 64'b0010);
        if (!v.we && !v.mis) chk("rdata_hold", o_rdata, v.rd);
    endtask

    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0;
        req_addr = '0; req_wdata = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

        tbl[0]  = tv(0, 0, 3'd2, 32'h1003, 0, 64'h80FF_1234, 0, 3, 0, 0, 32'h1000, 8'h08, 0, 64'hFFFF_FF80);
        tbl[1]  = tv(0, 1, 3'd4, 32'h2002, 64'hBEEF, 0, 1, 0, 0, 0, 32'h2000, 8'h0C, 64'hBEEF_0000, 0);
        tbl[2]  = tv(0, 0, 3'd4, 32'h3001, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0);
        tbl[3]  = tv(0, 1, 3'd0, 32'h4002, 64'h1234, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0);
        tbl[4]  = tv(0, 0, 3'd0, 32'h5000, 0, 64'hDEAD_BEEF, 4, 0, 0, 0, 32'h5000, 8'h0F, 0, 64'hDEAD_BEEF);
        tbl[5]  = tv(0, 0, 3'd3, 32'h6002, 0, 64'h9ABC_1234, 0, 1, 0, 0, 32'h6000, 8'h0C, 0, 64'h9ABC);
        tbl[6]  = tv(0, 0, 3'd1, 32'h7001, 0, 64'hF500, 1, 2, 0, 0, 32'h7000, 8'h02, 0, 64'hF5);
        tbl[7]  = tv(0, 0, 3'd4, 32'h8000, 0, 64'h1_8001, 0, 0, 0, 0, 32'h8000, 8'h03, 0, 64'hFFFF_8001);
        tbl[8]  = tv(0, 1, 3'd2, 32'h9003, 64'hA5, 0, 0, 0, 0, 0, 32'h9000, 8'h08, 64'hA500_0000, 0);
        tbl[9]  = tv(0, 0, 3'd6, 32'hA002, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0);
        tbl[10] = tv(0, 1, 3'd7, 32'hB000, 64'h1234_5678, 0, 2, 0, 0, 0, 32'hB000, 8'h0F, 64'h1234_5678, 0);
        tbl[11] = tv(0, 0, 3'd2, 32'hC000, 0, 64'h7F, 2, 2, 0, 0, 32'hC000, 8'h01, 0, 64'h7F);
        tbl[12] = tv(1, 0, 3'd6, 32'h104, 0, 64'h8000_0001_1234_5678, 0, 0, 0, 0, 32'h100, 8'hF0, 0,
                     64'hFFFF_FFFF_8000_0001);
        tbl[13] = tv(1, 1, 3'd0, 32'h200, 64'h1122_3344_5566_7788, 0, 1, 0, 0, 0, 32'h200, 8'hFF,
                     64'h1122_3344_5566_7788, 0);
        tbl[14] = tv(1, 0, 3'd5, 32'h104, 0, 64'h8000_0001_1234_5678, 0, 1, 0, 0, 32'h100, 8'hF0, 0,
                     64'h8000_0001);
        tbl[15] = tv(1, 0, 3'd6, 32'h102, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0);
        tbl[16] = tv(1, 1, 3'd0, 32'h204, 64'h55, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0);
        tbl[17] = tv(1, 0, 3'd4, 32'h10E, 0, 64'hABCD_0000_0000_0000, 0, 0, 0, 0, 32'h108, 8'hC0, 0,
                     64'hFFFF_FFFF_FFFF_ABCD);

        tick(); tick(); tick();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            tag = s[0] ? "reset64" : "reset32";
            #1;
            chk("ctrl", 64'({o_rr, o_busy, o_done, o_exc, o_mv}), 64'b10000);
            chk("exc_code", 64'(o_code), 64'd0);
            chk("rdata", o_rdata, 64'd0);
            chk("mem_addr", 64'(o_maddr), 64'd0);
            chk("mem_be", 64'(o_be), 64'd0);
            chk("mem_wdata", o_wdata, 64'd0);
        end

        for (int i = 0; i < 18; i++) begin
            tag = $sformatf("vec%0d", i);
            run(tbl[i]);
        end

        // Reset while waiting for read data, then the stale response arrives.
        tag = "rst_wait";
        sel64 = 1'b0;
        #1;
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h40;
        tick();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("in_wait", 64'({o_busy, o_mv, o_done}), 64'b100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_rst", 64'({o_rr, o_busy, o_mv, o_done, o_exc}), 64'b10000);
        chk("post_rst_rdata", o_rdata, 64'd0);
        chk("post_rst_be", 64'(o_be), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h5555_5555;
        tick();
        mem_rsp_valid = 1'b0;
        chk("late_rsp", 64'({o_done, o_busy, o_rr}), 64'b001);
        chk("late_rsp_rdata", o_rdata, 64'd0);
        tick();
        chk("late_rsp2", 64'({o_done, o_busy}), 64'b00);

        for (int i = 0; i < 240; i++) begin
            bit [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
            v = mk(i >= 160, 1'($urandom), 3'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            tag = $sformatf("rnd%0d", i);
            run(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
